// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, talks to
// instruction memory over a hold-until-ready handshake, and honours stall/flush/redirect.
module fetch_stage #(
  parameter int unsigned           ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [5:0]        ifid_opcode
);

  typedef enum logic [1:0] {REQ, DRAIN, BUF} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic [ADDR_W-1:0] buf_pc4;
  logic [31:0]       buf_instr;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              ready;
  logic              load_new;
  logic [31:0]       new_instr;
  logic [ADDR_W-1:0] new_pc4;

  assign pc_plus4     = pc + ADDR_W'(4);
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  assign imem_req    = ((state == REQ) || (state == DRAIN)) && !reset;
  assign imem_addr   = pc;
  assign ready       = imem_ready && imem_req;
  assign ifid_opcode = ifid_instr[31:26];

  // An instruction reaches IF/ID either straight from memory or from the stall buffer.
  always_comb begin
    load_new  = 1'b0;
    new_instr = imem_rdata;
    new_pc4   = pc_plus4;
    case (state)
      REQ: load_new = ready && !redirect_valid && !stall;
      BUF: begin
        load_new  = !redirect_valid && !stall;
        new_instr = buf_instr;
        new_pc4   = buf_pc4;
      end
      default: load_new = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pc         <= RESET_PC;
      pending_pc <= '0;
      buf_instr  <= '0;
      buf_pc4    <= '0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid && ready) begin
            pc <= redirect_tgt;
          end else if (redirect_valid) begin
            pending_pc <= redirect_tgt;
            state      <= DRAIN;
          end else if (ready && !stall) begin
            pc <= pc_plus4;
          end else if (ready) begin
            buf_instr <= imem_rdata;
            buf_pc4   <= pc_plus4;
            pc        <= pc_plus4;
            state     <= BUF;
          end
        end
        DRAIN: begin
          // The outstanding request must complete at the old pc before retargeting.
          if (ready) begin
            pc    <= redirect_valid ? redirect_tgt : pending_pc;
            state <= REQ;
          end else if (redirect_valid) begin
            pending_pc <= redirect_tgt;
          end
        end
        BUF: begin
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            state <= REQ;
          end else if (!stall) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase

      if (redirect_valid || flush) begin
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end else if (stall) begin
        ifid_valid <= ifid_valid;
      end else if (load_new) begin
        ifid_valid <= 1'b1;
        ifid_instr <= new_instr;
        ifid_pc4   <= new_pc4;
      end else begin
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID words go into a queue as the
// memory response is issued; a monitor pops them when the DUT loads a new instruction.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4;
  logic [5:0]  ifid_opcode;

  logic        reset2, imem_ready2;
  logic [31:0] imem_rdata2;
  logic        imem_req2, ifid_valid2;
  logic [31:0] imem_addr2, ifid_instr2, ifid_pc42;
  logic [5:0]  ifid_opcode2;

  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;
  logic stall_q = 1'b1;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_opcode(ifid_opcode)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(1'b0), .flush(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2),
    .imem_rdata(imem_rdata2), .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2),
    .ifid_pc4(ifid_pc42), .ifid_opcode(ifid_opcode2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    expq.push_back(e);
  endtask

  // A freshly loaded IF/ID entry shows up only after an edge where stall was low.
  always @(posedge clk) stall_q <= stall;

  always @(negedge clk) begin
    if (reset === 1'b0 && ifid_valid === 1'b1 && stall_q === 1'b0) begin
      if (expq.size() == 0) begin
        check("unexpected_ifid_instr", ifid_instr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pc4", ifid_pc4, e.pc4);
        check("ifid_opcode", {26'd0, ifid_opcode}, {26'd0, e.instr[31:26]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_ready = 1'b0; imem_rdata = '0;
    reset2 = 1'b1; imem_ready2 = 1'b0; imem_rdata2 = '0;

    repeat (2) @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_ifid_instr", ifid_instr, 32'd0);
    check("rst_ifid_pc4", ifid_pc4, 32'd0);

    // Back-to-back fetches
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h8C08_0004;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    push(32'h8C08_0004, 32'h4);
    @(negedge clk);
    check("addr_4", imem_addr, 32'h4);
    imem_rdata = 32'h0000_0020;
    push(32'h0000_0020, 32'h8);
    @(negedge clk);
    check("addr_8", imem_addr, 32'h8);

    // Stall while memory responds: response parks in the buffer
    stall = 1'b1; imem_rdata = 32'hAC09_0000;
    push(32'hAC09_0000, 32'hC);
    @(negedge clk);
    imem_ready = 1'b0;
    check("buf_req", {31'd0, imem_req}, 32'd0);
    check("buf_hold_instr", ifid_instr, 32'h0000_0020);
    @(negedge clk);
    check("buf_hold_req", {31'd0, imem_req}, 32'd0);
    check("buf_hold_pc4", ifid_pc4, 32'h8);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    check("release_instr", ifid_instr, 32'hAC09_0000);
    check("release_pc4", ifid_pc4, 32'hC);
    check("release_addr", imem_addr, 32'hC);
    check("release_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'h2408_0001;
    push(32'h2408_0001, 32'h10);
    @(negedge clk);
    check("addr_10", imem_addr, 32'h10);

    // Redirect while the request at 0x10 is outstanding
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drain_addr0", imem_addr, 32'h10);
    check("drain_valid0", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk);
    check("drain_addr1", imem_addr, 32'h10);
    check("drain_req1", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("redirect_addr", imem_addr, 32'h100);
    check("drain_drop_valid", {31'd0, ifid_valid}, 32'd0);

    // Redirect coinciding with imem_ready, then a misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h40; imem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("same_cycle_addr", imem_addr, 32'h40);
    check("same_cycle_valid", {31'd0, ifid_valid}, 32'd0);
    redirect_pc = 32'h43;
    @(negedge clk);
    check("mask_addr", imem_addr, 32'h40);
    redirect_valid = 1'b0; imem_rdata = 32'h3C01_1234;
    push(32'h3C01_1234, 32'h44);
    @(negedge clk);

    // flush beats stall
    flush = 1'b1; stall = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    check("flush_valid", {31'd0, ifid_valid}, 32'd0);
    check("flush_instr", ifid_instr, 32'd0);
    check("flush_pc4", ifid_pc4, 32'h44);
    flush = 1'b0; stall = 1'b0;

    // Reset arriving while draining, with a late memory response
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("drain2_addr", imem_addr, 32'h44);
    redirect_valid = 1'b0; reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    #1;
    check("rst2_req", {31'd0, imem_req}, 32'd0);
    check("rst2_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst2_instr", ifid_instr, 32'd0);
    check("rst2_pc4", ifid_pc4, 32'd0);
    check("rst2_addr", imem_addr, 32'd0);
    reset = 1'b0; imem_ready = 1'b0;
    #1;
    check("rst2_req_after", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    check("rst2_addr_hold", imem_addr, 32'h0);
    check("rst2_no_late", {31'd0, ifid_valid}, 32'd0);
    imem_ready = 1'b1; imem_rdata = 32'h0800_0010;
    push(32'h0800_0010, 32'h4);
    @(negedge clk);
    check("rst2_next_addr", imem_addr, 32'h4);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", expq.size(), 32'd0);

    // PC wrap-around at the top of the address space
    reset2 = 1'b0; imem_ready2 = 1'b1; imem_rdata2 = 32'h2000_0000;
    #1;
    check("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_ready2 = 1'b0;
    check("wrap_valid", {31'd0, ifid_valid2}, 32'd1);
    check("wrap_instr", ifid_instr2, 32'h2000_0000);
    check("wrap_pc4", ifid_pc42, 32'h0);
    check("wrap_opcode", {26'd0, ifid_opcode2}, 32'h8);
    check("wrap_addr", imem_addr2, 32'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the MIPS core; sits directly upstream of the main control decoder.
- Holds the PC and issues requests to instruction memory over a hold-until-ready handshake.
- Applies stall, flush and branch/jump redirect from later stages.
- Presents the fetched instruction, its PC+4 and the 6-bit opcode field to decode/control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold the IF/ID register and PC advance
flush  in  1  turn the IF/ID contents into a bubble
redirect_valid  in  1  branch taken or jump resolved downstream
redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address
imem_ready  in  1  memory completes the current request this cycle
imem_rdata  in  32  instruction word; valid when imem_ready=1
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pc4  out  ADDR_W  IF/ID PC+4
ifid_opcode  out  6  ifid_instr[31:26]; combinational; feeds main control

Behaviour:
- Reset (synchronous):
  - pc=RESET_PC, state=REQ, pending_pc=0, buffer cleared.
  - ifid_valid=0, ifid_instr=0, ifid_pc4=0.
  - imem_req=0 while reset is high. The first cycle after reset drives imem_req=1 with imem_addr=RESET_PC.
  - Reset asserted in any state, including mid-request, aborts all state. Any late imem_ready is ignored for one cycle after reset.
- Handshake:
  - Once imem_req=1, imem_addr stays stable until the cycle with imem_ready=1.
  - imem_req = (state==REQ or DRAIN) and !reset. imem_addr = pc.
  - imem_ready with imem_req=0 is ignored.
- States: REQ, DRAIN, BUF.
- REQ, in priority order:
  - redirect_valid & imem_ready: response dropped; pc<=redirect_pc; stay in REQ.
  - redirect_valid & !imem_ready: pending_pc<=redirect_pc; go to DRAIN.
  - imem_ready & !stall: capture into IF/ID; pc<=pc+4.
  - imem_ready & stall: buf_instr<=imem_rdata; buf_pc4<=pc+4; pc<=pc+4; go to BUF.
  - Otherwise: wait.
- DRAIN:
  - Request stays outstanding at the old pc.
  - A further redirect_valid overwrites pending_pc.
  - On imem_ready: response dropped; pc<=pending_pc (or redirect_pc if redirect_valid in the same cycle); go to REQ.
- BUF:
  - imem_req=0.
  - redirect_valid: buffer discarded; pc<=redirect_pc; go to REQ.
  - else !stall: IF/ID<=buffer; go to REQ.
  - else: hold.
- IF/ID update priority:
  1. redirect_valid or flush: ifid_valid<=0, ifid_instr<=0 (nop), ifid_pc4 unchanged. Applies even when stall=1.
  2. stall: hold all IF/ID fields.
  3. New instruction available (REQ capture or BUF release): load valid=1 with instr and pc4.
  4. Otherwise: bubble (ifid_valid<=0, ifid_instr<=0).
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W: 32'hFFFF_FFFC wraps to 0.
  - redirect_pc[1:0] is masked to 00.
- Throughput and latency:
  - Latency is 1 cycle from the imem_ready edge to ifid_valid.
  - With imem_ready held high and no stall, one instruction per cycle.
- Simultaneous events:
  - stall and flush together: flush wins for IF/ID content. PC behaviour follows the state rules above.

Test Plan:
- Reset then imem_ready=1 every cycle with rdata=0x8C08_0004, 0x0000_0020 at addr 0x0, 0x4 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; ifid_instr 0x8C080004 (opcode 0x23), then 0x00000020 (opcode 0x00); ifid_pc4 0x4, then 0x8.
- stall=1 while imem_ready=1 at addr 0x8 (rdata 0xAC09_0000) -> state BUF, imem_req=0, IF/ID held. stall drops after 3 cycles -> next cycle ifid_instr=0xAC090000, ifid_pc4=0xC, imem_addr=0xC.
- Redirect 0x100 while request at 0x10 outstanding (ready delayed 2 cycles) -> imem_addr stays 0x10 until ready; that response is never valid in IF/ID; next request addr=0x100; ifid_valid=0 meanwhile.
- Redirect 0x40 in the same cycle as imem_ready -> response dropped; next imem_addr=0x40; ifid_valid=0 for that cycle. Redirect 0x43 -> imem_addr=0x40.
- flush=1 with stall=1 while IF/ID valid -> ifid_valid=0, ifid_instr=0 next cycle. Reset asserted during DRAIN -> next cycle all outputs at reset values; a late imem_ready is ignored.
- RESET_PC=32'hFFFF_FFFC, one fetch -> ifid_pc4=0, next imem_addr=0x0.
